apb_timer: RTL and testbench
============================

Name: apb_timer

Overview:
- 32-bit down-counting timer, an APB slave on the peripheral side of the AHB-to-APB bridge.
- Consumes the bridge's PSEL/PENABLE/PWRITE/PADDR/PWDATA and returns PRDATA/PREADY/PSLVERR.
- Raises a level interrupt on underflow, in periodic or one-shot mode, with a 16-bit prescaler.

Parameters:
- ADDR_W, 12, number of PADDR bits decoded; upper bus address bits are not connected.
- RST_LOAD, 32'hFFFF_FFFF, reset value of the LOAD and VALUE registers.

Ports:
- HCLK  in  1  clock, shared with the AHB/APB fabric.
- HRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  APB select from the bridge.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address; bits [1:0] ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response for an unmapped offset.
- TIMER_IRQ  out  1  interrupt, active high.

Behaviour:
- Clock and reset: one clock, HCLK. HRESET is asynchronous and active-high; all state flops use it.
- Reset values: CTRL=0, LOAD=VALUE=RST_LOAD, PRESCALE=0, IF=0, prescale counter pcnt=0, PRDATA=0, PSLVERR=0, TIMER_IRQ=0, PREADY=1.
- Register map (word offsets):
  - 0x00 CTRL RW: [0] EN, [1] IE, [2] ONESHOT; other bits read 0.
  - 0x04 LOAD RW.
  - 0x08 VALUE RO; writes ignored but not an error.
  - 0x0C PRESCALE RW: [15:0].
  - 0x10 STATUS: [0] IF, write 1 to clear.
  - Any other offset: PSLVERR=1 during the access phase, PRDATA=0, write discarded.
- Transfer handshake:
  - A write commits on the HCLK edge where PSEL & PENABLE & PWRITE & PREADY.
  - PRDATA is driven only while PSEL & PENABLE & !PWRITE; it is 0 otherwise.
  - PSLVERR is asserted only in the access phase and only alongside PREADY.
  - PREADY is tied to 1: zero wait states, unless the optional feature below is compiled in.
- Prescaler, while EN=1:
  - pcnt increments each cycle.
  - When pcnt==PRESCALE, tick=1 and pcnt wraps to 0.
  - PRESCALE=0 gives a tick every cycle.
  - While EN=0, pcnt holds at 0 and VALUE holds.
- Counting, on each tick:
  - VALUE!=0: VALUE decrements by 1.
  - VALUE==0: IF is set. With ONESHOT=0, VALUE reloads from LOAD. With ONESHOT=1, EN clears and VALUE stays 0.
  - The period is therefore (LOAD+1)*(PRESCALE+1) cycles.
- Write side effects:
  - A LOAD write also copies PWDATA into VALUE and clears pcnt.
  - A CTRL write that takes EN from 0 to 1 clears pcnt.
- Simultaneous events:
  - LOAD write and tick in the same cycle: the write wins. VALUE=PWDATA, no decrement; IF is still set if VALUE was 0.
  - STATUS W1C and IF set in the same cycle: the set wins, IF stays 1.
  - CTRL write clearing EN and a tick in the same cycle: the tick is discarded.
- TIMER_IRQ = IF & IE, registered (one cycle after IF/IE change).
- Reset asserted mid-transfer: outputs take their reset values immediately; the transfer is lost.

Optional Feature:
- Macro: APB_TIMER_WAIT_EN.
- Defined: reads insert exactly one wait state.
  - The first access-phase cycle of a read has PREADY=0 and PRDATA=0.
  - The second cycle has PREADY=1 with PRDATA sampled from the register at the first cycle.
  - A one-bit wait flop tracks this and clears when PSEL drops.
  - Writes stay zero-wait.
- Undefined: PREADY is constant 1 and no wait flop exists.

Test Plan:
- Reset check: assert HRESET for 3 cycles, then read all offsets -> CTRL=0, LOAD=VALUE=0xFFFF_FFFF, PRESCALE=0, STATUS=0, PSLVERR=0, TIMER_IRQ=0.
- Periodic mode: write LOAD=3, PRESCALE=1, CTRL=0x3 -> IF sets every 8 cycles and TIMER_IRQ rises 1 cycle after IF. Write STATUS=1 -> TIMER_IRQ drops; it re-asserts 8 cycles after the previous set.
- One-shot mode: write LOAD=2, PRESCALE=0, CTRL=0x7 -> after 3 cycles IF=1, then reading CTRL returns 0x6 and VALUE stays 0 thereafter.
- Collision: time a STATUS W1C to land on the cycle IF sets -> STATUS reads 1. Time a LOAD=5 write to land on a tick -> VALUE reads 5.
- Error response: read offset 0x14 -> PSLVERR=1, PRDATA=0. Write 0x20 -> PSLVERR=1 and no register changes. Write VALUE -> PSLVERR=0 and VALUE unchanged.
- With APB_TIMER_WAIT_EN: read LOAD -> PREADY low for 1 access cycle, then high with the correct data. A back-to-back write completes in 2 cycles (setup + access).

Source files
------------

// File: rtl/apb_timer.sv
// apb_timer: 32-bit down-counting APB timer with a 16-bit prescaler and a level underflow interrupt.
// Optional macro APB_TIMER_WAIT_EN adds exactly one wait state to every read.
module apb_timer #(
   parameter int          ADDR_W   = 12,
   parameter logic [31:0] RST_LOAD = 32'hFFFF_FFFF
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              TIMER_IRQ
);
   localparam int OFF_W = ADDR_W - 2;
   localparam logic [OFF_W-1:0] OFF_CTRL  = OFF_W'(32'd0);
   localparam logic [OFF_W-1:0] OFF_LOAD  = OFF_W'(32'd1);
   localparam logic [OFF_W-1:0] OFF_VALUE = OFF_W'(32'd2);
   localparam logic [OFF_W-1:0] OFF_PRE   = OFF_W'(32'd3);
   localparam logic [OFF_W-1:0] OFF_STAT  = OFF_W'(32'd4);

   logic              r_en, r_ie, r_oneshot, r_if, r_irq;
   logic [31:0]       r_load, r_value;
   logic [15:0]       r_prescale, r_pcnt;
   logic [OFF_W-1:0]  w_off;
   logic              w_access, w_ready, w_mapped, w_wr;
   logic              w_wr_ctrl, w_wr_load, w_wr_pre, w_wr_stat;
   logic              w_en_rise, w_tick, w_underflow, w_unused;
   logic [31:0]       w_rdata, w_rdata_out;

   assign w_off    = PADDR[ADDR_W-1:2];
   assign w_unused = ^PADDR[1:0];
   // Gating with HRESET makes the bus outputs show reset values at once, even mid-transfer.
   assign w_access = PSEL & PENABLE & ~HRESET;

   always_comb begin
      w_mapped = 1'b1;
      w_rdata  = 32'd0;
      case (w_off)
         OFF_CTRL:  w_rdata = {29'd0, r_oneshot, r_ie, r_en};
         OFF_LOAD:  w_rdata = r_load;
         OFF_VALUE: w_rdata = r_value;
         OFF_PRE:   w_rdata = {16'd0, r_prescale};
         OFF_STAT:  w_rdata = {31'd0, r_if};
         default:   w_mapped = 1'b0;
      endcase
   end

`ifdef APB_TIMER_WAIT_EN
   logic        r_wait;
   logic [31:0] r_rdata_hold;

   // First read access cycle stalls and captures the data returned in the second.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_wait       <= 1'b0;
         r_rdata_hold <= 32'd0;
      end else begin
         r_wait <= w_access & ~PWRITE & ~r_wait;
         if (w_access & ~PWRITE & ~r_wait) begin
            r_rdata_hold <= w_rdata;
         end
      end
   end

   assign w_ready     = ~(w_access & ~PWRITE & ~r_wait);
   assign w_rdata_out = r_wait ? r_rdata_hold : w_rdata;
`else
   assign w_ready     = 1'b1;
   assign w_rdata_out = w_rdata;
`endif

   assign PREADY    = w_ready;
   assign PRDATA    = (w_access & ~PWRITE & w_ready) ? w_rdata_out : 32'd0;
   assign PSLVERR   = w_access & w_ready & ~w_mapped;
   assign TIMER_IRQ = r_irq;

   assign w_wr      = w_access & PWRITE & w_ready & w_mapped;
   assign w_wr_ctrl = w_wr & (w_off == OFF_CTRL);
   assign w_wr_load = w_wr & (w_off == OFF_LOAD);
   assign w_wr_pre  = w_wr & (w_off == OFF_PRE);
   assign w_wr_stat = w_wr & (w_off == OFF_STAT);
   assign w_en_rise = w_wr_ctrl & PWDATA[0] & ~r_en;
   // A CTRL write that turns the timer off swallows a coincident tick.
   assign w_tick      = r_en & (r_pcnt == r_prescale) & ~(w_wr_ctrl & ~PWDATA[0]);
   assign w_underflow = w_tick & (r_value == 32'd0);

   // Register file, prescaler, down-counter, interrupt flag and registered IRQ.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_en       <= 1'b0;
         r_ie       <= 1'b0;
         r_oneshot  <= 1'b0;
         r_load     <= RST_LOAD;
         r_value    <= RST_LOAD;
         r_prescale <= 16'd0;
         r_pcnt     <= 16'd0;
         r_if       <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         if (w_wr_ctrl) begin
            r_en      <= PWDATA[0];
            r_ie      <= PWDATA[1];
            r_oneshot <= PWDATA[2];
         end else if (w_underflow & r_oneshot) begin
            r_en <= 1'b0;
         end
         if (w_wr_pre) begin
            r_prescale <= PWDATA[15:0];
         end
         if (w_wr_load) begin
            r_load <= PWDATA;
         end
         if (w_wr_load) begin
            r_value <= PWDATA;
         end else if (w_tick) begin
            if (r_value != 32'd0) begin
               r_value <= r_value - 32'd1;
            end else if (!r_oneshot) begin
               r_value <= r_load;
            end else begin
               r_value <= 32'd0;
            end
         end
         if (w_wr_load | w_en_rise | ~r_en | w_tick) begin
            r_pcnt <= 16'd0;
         end else begin
            r_pcnt <= r_pcnt + 16'd1;
         end
         if (w_underflow) begin
            r_if <= 1'b1;
         end else if (w_wr_stat & PWDATA[0]) begin
            r_if <= 1'b0;
         end
         r_irq <= r_if & r_ie;
      end
   end
endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: register table, hand-timed corner sequences,
// and randomized runs checked against a closed-form timing model.
module tb_apb_timer;
   logic        HCLK = 1'b0;
   logic        HRESET, PSEL, PENABLE, PWRITE;
   logic [11:0] PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY, PSLVERR, TIMER_IRQ;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      bit          exp_err;
   } vec_t;
   vec_t vt[19];

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   apb_timer #(.ADDR_W(12), .RST_LOAD(32'hFFFF_FFFF)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR), .TIMER_IRQ(TIMER_IRQ)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Starts and ends just after a falling edge; s_cyc = edge count seen by the sampled data.
   task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err, output int s_cyc);
      int guard;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
      @(negedge HCLK);
      PENABLE = 1'b1;
      #1;
      s_cyc = cyc;
      if (wr) check("wr_prdata_zero", PRDATA, 32'd0);
`ifdef APB_TIMER_WAIT_EN
      if (!wr) begin
         check("wait_pready_low", {31'd0, PREADY}, 32'd0);
         check("wait_prdata_zero", PRDATA, 32'd0);
      end else begin
         check("wr_zero_wait", {31'd0, PREADY}, 32'd1);
      end
`endif
      guard = 0;
      while (PREADY !== 1'b1 && guard < 4) begin
         @(negedge HCLK);
         #1;
         guard++;
      end
      if (guard == 4) check("pready_timeout", {31'd0, PREADY}, 32'd1);
      rd  = PRDATA;
      err = PSLVERR;
      @(negedge HCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      logic [31:0] rd; logic err; int s;
      xfer(1'b1, a, d, rd, err, s);
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] data, output int s);
      logic err;
      xfer(1'b0, a, 32'd0, data, err, s);
   endtask

   // Closed-form state n clock edges after the enabling CTRL write (VALUE started at LOAD=l).
   task automatic model(input int n, input int l, input int p, input bit os, input bit ie,
                        output int val, output bit en, output bit flag, output bit irq);
      int k;
      k = n / (p + 1);
      if (k <= l) begin
         val = l - k; en = 1'b1; flag = 1'b0;
      end else if (os) begin
         val = 0; en = 1'b0; flag = 1'b1;
      end else begin
         val = l - ((k - l - 1) % (l + 1)); en = 1'b1; flag = 1'b1;
      end
      irq = ie && (n >= (l + 1) * (p + 1) + 1);
   endtask

   task automatic poll_irq(input bit level, output int at);
      int i;
      for (i = 0; i < 40; i++) begin
         if (TIMER_IRQ === level) break;
         @(negedge HCLK);
         #1;
      end
      at = cyc;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d; logic e; int s, c, at, val;
      bit m_en, m_if, m_irq;
      int l, p, w; bit os, ie;

      vt[0]  = '{1'b0, 12'h000, 32'h0,        32'h0000_0000, 1'b0};
      vt[1]  = '{1'b0, 12'h004, 32'h0,        32'hFFFF_FFFF, 1'b0};
      vt[2]  = '{1'b0, 12'h008, 32'h0,        32'hFFFF_FFFF, 1'b0};
      vt[3]  = '{1'b0, 12'h00C, 32'h0,        32'h0000_0000, 1'b0};
      vt[4]  = '{1'b0, 12'h010, 32'h0,        32'h0000_0000, 1'b0};
      vt[5]  = '{1'b0, 12'h014, 32'h0,        32'h0000_0000, 1'b1};
      vt[6]  = '{1'b1, 12'h020, 32'hDEAD_BEEF, 32'h0,        1'b1};
      vt[7]  = '{1'b0, 12'h004, 32'h0,        32'hFFFF_FFFF, 1'b0};
      vt[8]  = '{1'b0, 12'h000, 32'h0,        32'h0000_0000, 1'b0};
      vt[9]  = '{1'b1, 12'h008, 32'h0000_1234, 32'h0,        1'b0};
      vt[10] = '{1'b0, 12'h008, 32'h0,        32'hFFFF_FFFF, 1'b0};
      vt[11] = '{1'b1, 12'h00C, 32'hABCD_1234, 32'h0,        1'b0};
      vt[12] = '{1'b0, 12'h00E, 32'h0,        32'h0000_1234, 1'b0};
      vt[13] = '{1'b1, 12'h000, 32'hFFFF_FFF6, 32'h0,        1'b0};
      vt[14] = '{1'b0, 12'h000, 32'h0,        32'h0000_0006, 1'b0};
      vt[15] = '{1'b1, 12'h004, 32'h0000_0055, 32'h0,        1'b0};
      vt[16] = '{1'b0, 12'h008, 32'h0,        32'h0000_0055, 1'b0};
      vt[17] = '{1'b0, 12'h100, 32'h0,        32'h0000_0000, 1'b1};
      vt[18] = '{1'b1, 12'h000, 32'h0000_0000, 32'h0,        1'b0};

      // Reset held with an unmapped read access on the bus.
      HRESET = 1'b1; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 12'h014; PWDATA = 32'd0;
      repeat (3) @(negedge HCLK);
      #1;
      check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
      check("rst_prdata", PRDATA, 32'd0);
      check("rst_pready", {31'd0, PREADY}, 32'd1);
      check("rst_irq", {31'd0, TIMER_IRQ}, 32'd0);
      HRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      #1;
      check("idle_prdata", PRDATA, 32'd0);
      check("idle_pslverr", {31'd0, PSLVERR}, 32'd0);

      foreach (vt[i]) begin
         xfer(vt[i].wr, vt[i].addr, vt[i].wdata, d, e, s);
         if (!vt[i].wr) check($sformatf("tbl%0d_rdata", i), d, vt[i].exp_rd);
         check($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, vt[i].exp_err});
      end

      // Periodic: IF every 8 cycles, IRQ one cycle later, W1C drops it.
      wr(12'h00C, 32'd1); wr(12'h004, 32'd3); wr(12'h010, 32'd1); wr(12'h000, 32'd3);
      c = cyc;
      poll_irq(1'b1, at);
      check("per_irq_rise1", at - c, 32'd9);
      wr(12'h010, 32'd1);
      @(negedge HCLK); #1;
      check("per_irq_cleared", {31'd0, TIMER_IRQ}, 32'd0);
      poll_irq(1'b1, at);
      check("per_irq_rise2", at - c, 32'd17);

      // One-shot: three ticks to underflow, EN self-clears, VALUE parks at 0.
      wr(12'h000, 32'd0); wr(12'h010, 32'd1); wr(12'h00C, 32'd0); wr(12'h004, 32'd2);
      wr(12'h000, 32'd7);
      c = cyc;
      rd(12'h008, d, s); check("os_value_mid", d, 32'd1);
      rd(12'h010, d, s); check("os_status", d, 32'd1);
      rd(12'h000, d, s); check("os_ctrl", d, 32'd6);
      check("os_irq", {31'd0, TIMER_IRQ}, 32'd1);
      rd(12'h008, d, s); check("os_value0", d, 32'd0);
      repeat (5) @(negedge HCLK);
      rd(12'h008, d, s); check("os_value_stays0", d, 32'd0);

      // W1C landing on the edge where IF sets: set wins.
      wr(12'h000, 32'd0); wr(12'h010, 32'd1); wr(12'h00C, 32'd0); wr(12'h004, 32'd3);
      wr(12'h000, 32'd1);
      c = cyc;
      repeat (4) @(negedge HCLK);
      wr(12'h010, 32'd1);
      wr(12'h010, 32'd1);
      check("w1c_commit_cycle", cyc - c, 32'd8);
      rd(12'h010, d, s); check("w1c_collide_status", d, 32'd1);

      // LOAD write landing on the underflow tick: write wins, IF still sets.
      wr(12'h000, 32'd0); wr(12'h010, 32'd1); wr(12'h00C, 32'd3); wr(12'h004, 32'd3);
      wr(12'h000, 32'd1);
      c = cyc;
      repeat (14) @(negedge HCLK);
      wr(12'h004, 32'd5);
      check("load_commit_cycle", cyc - c, 32'd16);
      rd(12'h008, d, s); check("load_collide_value", d, 32'd5);
      rd(12'h010, d, s); check("load_collide_if", d, 32'd1);

      // Randomized runs against the closed-form model.
      for (int it = 0; it < 25; it++) begin
         l = $urandom_range(0, 9); p = $urandom_range(0, 3);
         os = 1'($urandom_range(0, 1)); ie = 1'($urandom_range(0, 1));
         w = $urandom_range(0, 40);
         wr(12'h000, 32'd0); wr(12'h00C, 32'(p)); wr(12'h004, 32'(l)); wr(12'h010, 32'd1);
         wr(12'h000, {29'd0, os, ie, 1'b1});
         c = cyc;
         repeat (w) @(negedge HCLK);
         #1;
         model(cyc - c, l, p, os, ie, val, m_en, m_if, m_irq);
         check($sformatf("rnd%0d_irq", it), {31'd0, TIMER_IRQ}, {31'd0, m_irq});
         rd(12'h008, d, s);
         model(s - c, l, p, os, ie, val, m_en, m_if, m_irq);
         check($sformatf("rnd%0d_value", it), d, 32'(val));
         rd(12'h010, d, s);
         model(s - c, l, p, os, ie, val, m_en, m_if, m_irq);
         check($sformatf("rnd%0d_status", it), d, {31'd0, m_if});
         rd(12'h000, d, s);
         model(s - c, l, p, os, ie, val, m_en, m_if, m_irq);
         check($sformatf("rnd%0d_ctrl", it), d, {29'd0, os, ie, m_en});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
